// File: rtl/stc_abuffer_ctrl.sv
// Sequencer for the sparse tensor core A buffer: loads M data rows, then M column-index
// rows, then streams the nnz compressed entries out four lanes per beat.
module stc_abuffer_ctrl #(
    parameter int M      = 16,
    parameter int DW_COL = 4,
    parameter int DW_PTR = 8,
    parameter int LANES  = 4
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      start_i,
    input  logic                      reload_i,
    input  logic [DW_PTR:0]           nnz_i,
    input  logic                      row_valid_i,
    output logic                      row_ready_o,
    output logic                      write_data_en_o,
    output logic                      write_cidx_en_o,
    output logic [DW_COL-1:0]         idx_o,
    output logic [DW_PTR*LANES-1:0]   ptrs_o,
    output logic                      out_valid_o,
    output logic [LANES-1:0]          out_mask_o,
    input  logic                      out_ready_i,
    output logic                      busy_o,
    output logic                      done_o
);

    typedef enum logic [2:0] {
        IDLE,
        LD_DATA,
        LD_CIDX,
        STREAM,
        DONE
    } state_t;

    state_t            state_q;
    logic [DW_COL-1:0] idx_q;
    logic [DW_PTR:0]   base_q;
    logic [DW_PTR:0]   nnz_q;
    logic [DW_PTR:0]   baseNext_d;
    logic [DW_PTR:0]   laneIdx_d [LANES];

    assign baseNext_d = base_q + (DW_PTR+1)'(LANES);

    // base is one bit wider than a ptr lane so a full 256-entry stream ends without wrapping
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            base_q  <= '0;
            nnz_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        nnz_q  <= nnz_i;
                        base_q <= '0;
                        idx_q  <= '0;
                        if (reload_i)
                            state_q <= LD_DATA;
                        else if (nnz_i != '0)
                            state_q <= STREAM;
                        else
                            state_q <= DONE;
                    end
                end
                LD_DATA: begin
                    if (row_valid_i) begin
                        if (idx_q == DW_COL'(M-1)) begin
                            idx_q   <= '0;
                            state_q <= LD_CIDX;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                LD_CIDX: begin
                    if (row_valid_i) begin
                        if (idx_q == DW_COL'(M-1)) begin
                            idx_q   <= '0;
                            state_q <= (nnz_q != '0) ? STREAM : DONE;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (out_ready_i) begin
                        base_q <= baseNext_d;
                        if (baseNext_d >= nnz_q)
                            state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Lanes past nnz are masked off and park their pointer at 0
    always_comb begin
        ptrs_o     = '0;
        out_mask_o = '0;
        for (int j = 0; j < LANES; j++) begin
            laneIdx_d[j] = base_q + (DW_PTR+1)'(j);
            if (state_q == STREAM && laneIdx_d[j] < nnz_q) begin
                out_mask_o[j]                = 1'b1;
                ptrs_o[j*DW_PTR +: DW_PTR]   = laneIdx_d[j][DW_PTR-1:0];
            end
        end
    end

    assign row_ready_o     = (state_q == LD_DATA) || (state_q == LD_CIDX);
    assign write_data_en_o = (state_q == LD_DATA) && row_valid_i;
    assign write_cidx_en_o = (state_q == LD_CIDX) && row_valid_i;
    assign idx_o           = idx_q;
    assign out_valid_o     = (state_q == STREAM);
    assign busy_o          = (state_q != IDLE);
    assign done_o          = (state_q == DONE);

endmodule
